// File: rtl/or_vector_source_scanner.sv
// Captures a bubble-corrected input vector on Start and streams the index of
// every set bit, lowest first, over a valid/ready handshake, then pulses Done.
module or_vector_source_scanner #(
  parameter int          WIDTH       = 17,
  parameter logic [31:0] BubblesMask = 32'h0,
  localparam int         IW          = $clog2(WIDTH),
  localparam int         CW          = $clog2(WIDTH + 1)
) (
  input  logic             Clock_i,
  input  logic             Reset_ni,
  input  logic             Start_i,
  input  logic [WIDTH-1:0] Input_Vector_i,
  output logic             Busy_o,
  output logic             Any_o,
  output logic [CW-1:0]    Hit_Count_o,
  output logic             Index_Valid_o,
  output logic [IW-1:0]    Index_o,
  input  logic             Index_Ready_i,
  output logic             Last_o,
  output logic             Done_o
);

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] vec_q, vec_d;
  logic             any_q;
  logic [CW-1:0]    cnt_q;

  logic [WIDTH-1:0] masked;
  logic [WIDTH-1:0] vecLowCleared;
  logic [CW-1:0]    popCount;
  logic [IW-1:0]    lowIdx;
  logic             capture;
  logic             oneLeft;

  assign masked        = Input_Vector_i ^ BubblesMask[WIDTH-1:0];
  assign capture       = (state_q == IDLE) && Start_i;
  assign vecLowCleared = vec_q & (vec_q - WIDTH'(1));
  assign oneLeft       = (vec_q != '0) && (vecLowCleared == '0);

  always_comb begin
    popCount = '0;
    for (int i = 0; i < WIDTH; i++) popCount = popCount + CW'(masked[i]);
  end

  // Scanning downwards leaves the lowest set position as the final winner.
  always_comb begin
    lowIdx = '0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (vec_q[i]) lowIdx = IW'(i);
    end
  end

  always_comb begin
    state_d = state_q;
    vec_d   = vec_q;
    case (state_q)
      IDLE: begin
        if (Start_i) begin
          vec_d   = masked;
          state_d = (masked != '0) ? SCAN : DONE;
        end
      end
      SCAN: begin
        if (Index_Ready_i) begin
          vec_d = vecLowCleared;
          if (oneLeft) state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clock_i or negedge Reset_ni) begin
    if (!Reset_ni) begin
      state_q <= IDLE;
      vec_q   <= '0;
      any_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      if (capture) begin
        any_q <= |masked;
        cnt_q <= popCount;
      end
    end
  end

  assign Busy_o        = (state_q != IDLE);
  assign Index_Valid_o = (state_q == SCAN);
  assign Index_o       = (state_q == SCAN) ? lowIdx : '0;
  assign Last_o        = (state_q == SCAN) && oneLeft;
  assign Done_o        = (state_q == DONE);
  assign Any_o         = any_q;
  assign Hit_Count_o   = cnt_q;

endmodule

// File: tb/tb_or_vector_source_scanner.sv
// Self-checking bench: directed scenarios plus random vectors with random
// backpressure, compared against a list-of-set-bits reference model.
module tb_or_vector_source_scanner;

  logic        Clock;
  logic        Reset_n;
  logic        start;
  logic        sel;
  logic [16:0] inVec;
  logic        ready;

  logic        startA, startB;
  logic        busyA, anyA, validA, lastA, doneA;
  logic [4:0]  hitA, idxA;
  logic        busyB, anyB, validB, lastB, doneB;
  logic [4:0]  hitB, idxB;

  logic        busy, any, valid, last, done;
  logic [4:0]  hit, idx;

  int nAsserts = 0;
  int nFail    = 0;

  assign startA = start & ~sel;
  assign startB = start & sel;
  assign busy   = sel ? busyB  : busyA;
  assign any    = sel ? anyB   : anyA;
  assign valid  = sel ? validB : validA;
  assign last   = sel ? lastB  : lastA;
  assign done   = sel ? doneB  : doneA;
  assign hit    = sel ? hitB   : hitA;
  assign idx    = sel ? idxB   : idxA;

  or_vector_source_scanner #(.WIDTH(17), .BubblesMask(32'h0)) dut (
    .Clock_i(Clock), .Reset_ni(Reset_n), .Start_i(startA), .Input_Vector_i(inVec),
    .Busy_o(busyA), .Any_o(anyA), .Hit_Count_o(hitA), .Index_Valid_o(validA),
    .Index_o(idxA), .Index_Ready_i(ready), .Last_o(lastA), .Done_o(doneA));

  or_vector_source_scanner #(.WIDTH(17), .BubblesMask(32'h1)) dutB (
    .Clock_i(Clock), .Reset_ni(Reset_n), .Start_i(startB), .Input_Vector_i(inVec),
    .Busy_o(busyB), .Any_o(anyB), .Hit_Count_o(hitB), .Index_Valid_o(validB),
    .Index_o(idxB), .Index_Ready_i(ready), .Last_o(lastB), .Done_o(doneB));

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nAsserts++;
    assert (obs === exp) else begin
      nFail++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // mode 0: ready always high, 1: random ready, 2: ready low for the first 4 cycles.
  // startAt >= 0 pulses a foreign Start while that index is being presented.
  task automatic applyStimulus(input logic [16:0] vec, input int mode, input int startAt);
    logic [16:0] mask;
    logic [16:0] masked;
    int expIdx[$];
    int k;
    int cyc;
    int stall;
    mask   = sel ? 17'h00001 : 17'h00000;
    masked = vec ^ mask;
    expIdx = {};
    for (int i = 0; i < 17; i++) if (masked[i]) expIdx.push_back(i);

    @(negedge Clock);
    inVec = vec;
    start = 1'b1;
    ready = 1'b0;
    @(negedge Clock);
    start = 1'b0;
    checkOutput("any", {31'd0, any}, {31'd0, expIdx.size() != 0});
    checkOutput("hitCount", {27'd0, hit}, expIdx.size());
    checkOutput("busyAfterStart", {31'd0, busy}, 32'd1);

    k = 0;
    cyc = 0;
    stall = 0;
    while (k < expIdx.size()) begin
      if (cyc > 300) begin
        checkOutput("scanTimeout", k, expIdx.size());
        break;
      end
      case (mode)
        0: ready = 1'b1;
        1: ready = (stall >= 6) ? 1'b1 : 1'($urandom_range(0, 1));
        default: ready = (cyc >= 4);
      endcase
      stall = ready ? 0 : stall + 1;
      if (k == startAt && startAt >= 0) begin
        start = 1'b1;
        inVec = 17'h00002;
      end else begin
        start = 1'b0;
      end
      checkOutput("indexValid", {31'd0, valid}, 32'd1);
      checkOutput("index", {27'd0, idx}, expIdx[k]);
      checkOutput("last", {31'd0, last}, {31'd0, k == expIdx.size() - 1});
      checkOutput("doneDuringScan", {31'd0, done}, 32'd0);
      @(posedge Clock);
      if (ready) k++;
      @(negedge Clock);
      cyc++;
    end
    start = 1'b0;
    ready = 1'b0;
    checkOutput("done", {31'd0, done}, 32'd1);
    checkOutput("validInDone", {31'd0, valid}, 32'd0);
    checkOutput("busyInDone", {31'd0, busy}, 32'd1);
    @(negedge Clock);
    checkOutput("doneOneCycle", {31'd0, done}, 32'd0);
    checkOutput("busyIdle", {31'd0, busy}, 32'd0);
    checkOutput("anyHeld", {31'd0, any}, {31'd0, expIdx.size() != 0});
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "Busy"}, {31'd0, busy}, 32'd0);
    checkOutput({tag, "Any"}, {31'd0, any}, 32'd0);
    checkOutput({tag, "Hit"}, {27'd0, hit}, 32'd0);
    checkOutput({tag, "Valid"}, {31'd0, valid}, 32'd0);
    checkOutput({tag, "Index"}, {27'd0, idx}, 32'd0);
    checkOutput({tag, "Last"}, {31'd0, last}, 32'd0);
    checkOutput({tag, "Done"}, {31'd0, done}, 32'd0);
  endtask

  initial begin
    Reset_n = 1'b0;
    start   = 1'b0;
    sel     = 1'b0;
    inVec   = '0;
    ready   = 1'b0;
    repeat (3) @(negedge Clock);
    checkAllZero("reset");
    Reset_n = 1'b1;
    @(negedge Clock);

    applyStimulus(17'h00000, 0, -1);
    applyStimulus(17'h10005, 0, -1);
    applyStimulus(17'h00012, 2, -1);
    sel = 1'b1;
    applyStimulus(17'h00000, 0, -1);
    sel = 1'b0;
    applyStimulus(17'h1FFFF, 0, 5);

    // Reset while index 3 of 0xF8 is on offer.
    @(negedge Clock);
    inVec = 17'h000F8;
    start = 1'b1;
    @(negedge Clock);
    start = 1'b0;
    ready = 1'b1;
    checkOutput("preResetIndex", {27'd0, idx}, 32'd3);
    Reset_n = 1'b0;
    #1;
    checkAllZero("midReset");
    @(negedge Clock);
    Reset_n = 1'b1;
    ready = 1'b0;
    repeat (3) begin
      @(negedge Clock);
      checkOutput("noDoneAfterReset", {31'd0, done}, 32'd0);
      checkOutput("idleAfterReset", {31'd0, busy}, 32'd0);
    end
    applyStimulus(17'h00040, 0, -1);

    for (int n = 0; n < 24; n++) begin
      logic [16:0] rv;
      rv = 17'($urandom);
      if ($urandom_range(0, 5) == 0) rv = '0;
      sel = 1'($urandom_range(0, 1));
      applyStimulus(rv, 1, -1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFail);
    $finish;
  end

endmodule

// File: doc/or_vector_source_scanner.md
Name: or_vector_source_scanner

Overview:
- Inverse companion to the wide OR-reduction gates: the OR gate collapses up to 17 inputs into one "any" flag; this block expands the flag back into which inputs caused it.
- Captures a 17-bit input vector with per-input bubble inversion on a Start pulse.
- Streams the index of every asserted input, lowest first, over a valid/ready handshake, then pulses Done.
- Feeds the recognition datapath's hit-location logic, e.g. which pixel or neuron lines fired.

Parameters:
- WIDTH, 17, number of input lines scanned; supported range 2..32.
- BubblesMask, 0, bit i = 1 inverts Input_Vector[i] before capture; same semantics as the OR gate bubbles.

Ports:
- Clock  input  1  system clock, rising edge.
- Reset_n  input  1  asynchronous, active-low reset.
- Start  input  1  capture request; sampled only in IDLE.
- Input_Vector  input  WIDTH  raw input lines.
- Busy  output  1  high in SCAN and DONE.
- Any  output  1  registered OR of the captured (post-bubble) vector.
- Hit_Count  output  clog2(WIDTH+1)  popcount of the captured vector; 5 bits at default.
- Index_Valid  output  1  Index is valid.
- Index  output  clog2(WIDTH)  position of the lowest remaining set bit; 5 bits at default.
- Index_Ready  input  1  consumer accepts Index.
- Last  output  1  current Index is the final one.
- Done  output  1  one-cycle pulse at end of scan.

Behaviour:
- Reset (asynchronous, Reset_n = 0):
  - State = IDLE, capture register = 0.
  - Busy, Any, Hit_Count, Index_Valid, Index, Last, Done all 0.
  - Applies immediately, including mid-scan; a partially streamed vector is discarded and no Done is issued.
- Capture:
  - masked = Input_Vector XOR BubblesMask[WIDTH-1:0].
  - At the edge where state = IDLE and Start = 1: register masked, load Any = |masked and Hit_Count = popcount(masked).
  - Any and Hit_Count hold until the next capture.
- States:
  - IDLE: Busy = 0. Start = 1 with masked != 0 -> SCAN. Start = 1 with masked = 0 -> DONE.
  - SCAN: Index_Valid = 1; Index = lowest set bit of the remaining register; Last = 1 when exactly one bit remains.
    - On Index_Valid & Index_Ready: clear that bit.
    - If Last was 1, go to DONE; otherwise stay in SCAN and present the next index in the following cycle.
  - DONE: Done = 1 for exactly one cycle, Index_Valid = 0, then -> IDLE.
- Handshake rules:
  - While Index_Valid = 1 and Index_Ready = 0, Index and Last hold stable.
  - Index_Valid never drops without a handshake.
  - Index_Ready is ignored outside SCAN.
- Throughput: one index per cycle under continuous Ready.
- Latency:
  - Start at edge t -> first Index_Valid visible after edge t, i.e. the cycle t+1.
  - Final handshake at edge u -> Done high in cycle u+1.
  - Zero vector: Done high in cycle t+1; Index_Valid never asserted.
- Start while Busy = 1 is ignored; no re-capture, no queuing.
- Index, Last, Index_Valid, Done, Busy are registered or decoded from registered state only; no combinational path from Input_Vector to outputs.
- Priority: lowest index first, strictly ascending. Bit WIDTH-1 is the last index possible.

Test Plan:
- Zero vector: Reset, Start with Input_Vector = 0x00000, BubblesMask = 0 -> cycle t+1: Done = 1, Any = 0, Hit_Count = 0, Index_Valid never 1, Busy = 1 for one cycle only.
- Sparse vector: Start with 0x10005, Index_Ready held 1 -> Index 0, 2, 16 on consecutive cycles; Last = 1 only with 16; Done the next cycle; Any = 1; Hit_Count = 3.
- Backpressure: vector 0x00012, Index_Ready = 0 for 4 cycles, then 1 -> Index = 1 held stable across all 4 stall cycles; then Index 4 with Last = 1; Done follows.
- Bubbles: BubblesMask = 0x00001, Input_Vector = 0x00000 -> Any = 1, Hit_Count = 1, single Index 0 with Last = 1.
- All ones and Start during scan: 0x1FFFF with Ready = 1 -> indices 0..16 over 17 cycles, Hit_Count = 17. A Start pulsed with 0x00002 at index 5 is ignored and the sequence is unaltered.
- Reset mid-scan: Reset_n low while Index = 3 of 0x000F8 -> all outputs 0 immediately, no Done. A new Start with 0x00040 -> single Index 6.
